// File: rtl/memory_pkg.sv
// Shared types and helpers for the byte-writable dual-port RAM.
package memory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_e;

    localparam int RDW_OLD = 32'sd0;
    localparam int RDW_NEW = 32'sd1;

    function automatic int num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/mem_init_ctrl.sv
// Clear engine: walks every address once after reset, then hands the write port over.
module mem_init_ctrl
    import memory_pkg::*;
#(
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    init_state_e           state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0] clr_addr_r, clr_addr_nxt_s;
    logic                  busy_r, busy_nxt_s;

    // State, counter and busy flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= CLEAR;
            clr_addr_r <= '0;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            clr_addr_r <= clr_addr_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    // Next-state logic; busy drops on the same edge that writes the last word.
    always_comb begin
        state_nxt_s    = state_r;
        clr_addr_nxt_s = clr_addr_r;
        busy_nxt_s     = busy_r;
        clr_we         = 1'b0;
        case (state_r)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_addr_r == LAST_ADDR) begin
                    state_nxt_s    = READY;
                    busy_nxt_s     = 1'b0;
                    clr_addr_nxt_s = '0;
                end else begin
                    clr_addr_nxt_s = clr_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            READY: begin
                busy_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s    = CLEAR;
                clr_addr_nxt_s = '0;
                busy_nxt_s     = 1'b1;
            end
        endcase
    end

    assign init_busy = busy_r;
    assign clr_addr  = clr_addr_r;

endmodule

// File: rtl/memory_dp_be.sv
// Simple dual-port RAM with per-byte write enables, registered reads and a post-reset clear.
module memory_dp_be
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             init_busy,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid
);

    localparam int NB = num_bytes(DATA_WIDTH, BYTE_WIDTH);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("RD_LATENCY must be 1 or 2");
    end
    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("DEPTH exceeds the address space");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
        $error("RDW_MODE must be 0 or 1");
    end

    logic                  clr_we_s;
    logic [ADDR_WIDTH-1:0] clr_addr_s;

    mem_init_ctrl #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .clr_we    (clr_we_s),
        .clr_addr  (clr_addr_s)
    );

    logic wr_in_range_s, rd_in_range_s;

    if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
        assign wr_in_range_s = 1'b1;
        assign rd_in_range_s = 1'b1;
    end else begin : g_partial_range
        assign wr_in_range_s = (wr_addr < ADDR_WIDTH'(DEPTH));
        assign rd_in_range_s = (rd_addr < ADDR_WIDTH'(DEPTH));
    end

    reg   [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [NB-1:0]         mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic                  rd_accept_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // Write-port mux: the clear engine owns the port until it finishes.
    always_comb begin
        mem_we_s    = '0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = wr_data;
        if (rst) begin
            mem_we_s = '0;
        end else if (clr_we_s) begin
            mem_we_s    = '1;
            mem_waddr_s = clr_addr_s;
            mem_wdata_s = '0;
        end else if (wr_en && wr_in_range_s) begin
            mem_we_s = wr_be;
        end else begin
            mem_we_s = '0;
        end
    end

    assign rd_accept_s = rd_en && !clr_we_s && !rst;

    // Read word with optional same-address forwarding of the freshly written lanes.
    always_comb begin
        rd_word_s = '0;
        if (rd_in_range_s) begin
            rd_word_s = mem[rd_addr];
            if (RDW_MODE == RDW_NEW && mem_waddr_s == rd_addr) begin
                for (int i = 0; i < NB; i++) begin
                    if (mem_we_s[i]) begin
                        rd_word_s[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_wdata_s[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end else begin
                        rd_word_s[i*BYTE_WIDTH +: BYTE_WIDTH] = mem[rd_addr][i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end else begin
                rd_word_s = mem[rd_addr];
            end
        end else begin
            rd_word_s = '0;
        end
    end

    // Per-lane array write so synthesis maps onto byte-enabled block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_we_s[i]) begin
                mem[mem_waddr_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata_s[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    logic                  rd_v1_r;
    logic [DATA_WIDTH-1:0] rd_d1_r;

    // First read stage; data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v1_r <= 1'b0;
            rd_d1_r <= '0;
        end else begin
            rd_v1_r <= rd_accept_s;
            if (rd_accept_s) begin
                rd_d1_r <= rd_word_s;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  rd_v2_r;
        logic [DATA_WIDTH-1:0] rd_d2_r;

        // Extra output register stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_v2_r <= 1'b0;
                rd_d2_r <= '0;
            end else begin
                rd_v2_r <= rd_v1_r;
                if (rd_v1_r) begin
                    rd_d2_r <= rd_d1_r;
                end
            end
        end

        assign rd_valid = rd_v2_r;
        assign rd_data  = rd_d2_r;
    end else begin : g_lat1
        assign rd_valid = rd_v1_r;
        assign rd_data  = rd_d1_r;
    end

endmodule

// File: tb/tb_memory_dp_be.sv
// Randomized scoreboard bench: two instances (default, and 3000-deep / latency 2 / new-data RDW).
module tb_memory_dp_be;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [11:0] wr_addr = 12'd0;
    logic [15:0] wr_data = 16'd0;
    logic [1:0]  wr_be = 2'b00;
    logic        rd_en = 1'b0;
    logic [11:0] rd_addr = 12'd0;

    logic        busy_a, busy_b, valid_a, valid_b;
    logic [15:0] data_a, data_b;

    always #5 clk = ~clk;

    memory_dp_be #(
        .DATA_WIDTH(16), .BYTE_WIDTH(8), .DEPTH(4096), .ADDR_WIDTH(12),
        .RD_LATENCY(1), .RDW_MODE(0)
    ) dut_a (
        .clk(clk), .rst(rst), .init_busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_a), .rd_valid(valid_a)
    );

    memory_dp_be #(
        .DATA_WIDTH(16), .BYTE_WIDTH(8), .DEPTH(3000), .ADDR_WIDTH(12),
        .RD_LATENCY(2), .RDW_MODE(1)
    ) dut_b (
        .clk(clk), .rst(rst), .init_busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_b), .rd_valid(valid_b)
    );

    typedef struct packed {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] mdl [2][4096];
    int          depth_k [2] = '{4096, 3000};
    int          lat_k   [2] = '{1, 2};
    bit          rdw_new_k [2] = '{1'b0, 1'b1};
    int          ready_k [2] = '{0, 0};
    int          cyc = 0;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input int k, input logic [15:0] act);
        exp_t e;
        bit   empty;
        empty = (k == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
        if (empty) begin
            check($sformatf("unexpected_rd_valid[%0d]", k), 32'd1, 32'd0);
        end else begin
            if (k == 0) e = q_a.pop_front();
            else        e = q_b.pop_front();
            check($sformatf("rd_data[%0d]", k), {16'd0, act}, {16'd0, e.data});
            check($sformatf("rd_cycle[%0d]", k), cyc, e.cyc);
        end
    endtask

    // Monitor: busy window and every rd_valid pulse against the scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            check("init_busy[0]", {31'd0, busy_a}, {31'd0, cyc < ready_k[0]});
            check("init_busy[1]", {31'd0, busy_b}, {31'd0, cyc < ready_k[1]});
        end
        if (valid_a === 1'b1) pop_check(0, data_a);
        if (valid_b === 1'b1) pop_check(1, data_b);
    end

    // Issue one cycle of traffic and predict each instance's response.
    task automatic op(input bit we, input logic [11:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input bit re, input logic [11:0] ra);
        logic [15:0] exp;
        exp_t        e;
        @(posedge clk); #1;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        for (int k = 0; k < 2; k++) begin
            if (cyc >= ready_k[k]) begin
                if (re) begin
                    exp = (int'(ra) < depth_k[k]) ? mdl[k][ra] : 16'h0000;
                    if (rdw_new_k[k] && we && wa == ra && int'(wa) < depth_k[k]) begin
                        if (be[0]) exp[7:0]  = wd[7:0];
                        if (be[1]) exp[15:8] = wd[15:8];
                    end
                    e.data = exp;
                    e.cyc  = cyc + lat_k[k];
                    if (k == 0) q_a.push_back(e);
                    else        q_b.push_back(e);
                end
                if (we && int'(wa) < depth_k[k]) begin
                    if (be[0]) mdl[k][wa][7:0]  = wd[7:0];
                    if (be[1]) mdl[k][wa][15:8] = wd[15:8];
                end
            end
        end
    endtask

    function automatic logic [11:0] pick_addr();
        int s;
        s = $urandom_range(0, 9);
        if (s < 6) return 12'($urandom_range(0, 15));
        case ($urandom_range(0, 4))
            0:       return 12'd404;
            1:       return 12'd3500;
            2:       return 12'hFFF;
            3:       return 12'd2999;
            default: return 12'd3000;
        endcase
    endfunction

    task automatic rand_op();
        logic [11:0] wa, ra;
        wa = pick_addr();
        ra = ($urandom_range(0, 7) == 0) ? wa : pick_addr();
        op(bit'($urandom_range(0, 1)), wa, 16'($urandom), 2'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), ra);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        chk_en = 1'b0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        for (int k = 0; k < 2; k++) begin
            ready_k[k] = cyc + depth_k[k];
            for (int a = 0; a < 4096; a++) mdl[k][a] = 16'h0000;
        end
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_rd_valid[0]", {31'd0, valid_a}, 32'd0);
        check("reset_rd_valid[1]", {31'd0, valid_b}, 32'd0);
        check("reset_rd_data[0]", {16'd0, data_a}, 32'd0);
        check("reset_rd_data[1]", {16'd0, data_b}, 32'd0);
    endtask

    task automatic run_through_clear();
        while (cyc < ready_k[0] + 2) rand_op();
    endtask

    initial begin
        do_reset();
        run_through_clear();

        op(1'b1, 12'd5, 16'hABCD, 2'b11, 1'b0, 12'd0);
        op(1'b1, 12'd5, 16'h1200, 2'b10, 1'b0, 12'd0);
        op(1'b0, 12'd0, 16'h0000, 2'b00, 1'b1, 12'd5);
        op(1'b1, 12'd7, 16'h1111, 2'b11, 1'b0, 12'd0);
        op(1'b1, 12'd7, 16'h2222, 2'b01, 1'b1, 12'd7);
        op(1'b0, 12'd0, 16'h0000, 2'b00, 1'b1, 12'd1);
        op(1'b0, 12'd0, 16'h0000, 2'b00, 1'b1, 12'd2);
        op(1'b0, 12'd0, 16'h0000, 2'b00, 1'b1, 12'd3);
        op(1'b0, 12'd0, 16'h0000, 2'b00, 1'b1, 12'hFFF);
        op(1'b1, 12'd404, 16'h0404, 2'b11, 1'b0, 12'd0);
        op(1'b1, 12'd3500, 16'hBEEF, 2'b11, 1'b0, 12'd0);
        op(1'b0, 12'd0, 16'h0000, 2'b00, 1'b1, 12'd3500);
        op(1'b0, 12'd0, 16'h0000, 2'b00, 1'b1, 12'd404);
        op(1'b1, 12'd9, 16'h5A5A, 2'b00, 1'b1, 12'd9);

        repeat (1500) rand_op();

        do_reset();
        repeat (100) rand_op();
        do_reset();
        run_through_clear();
        repeat (300) rand_op();

        op(1'b0, 12'd0, 16'h0000, 2'b00, 1'b1, 12'd5);
        do_reset();
        run_through_clear();
        repeat (200) rand_op();

        repeat (4) op(1'b0, 12'd0, 16'h0000, 2'b00, 1'b0, 12'd0);
        @(negedge clk);
        check("drain_queue[0]", q_a.size(), 32'd0);
        check("drain_queue[1]", q_b.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
